// File: rtl/tile_mixer_pkg.sv
// Shared widths, constants and helpers for the two-layer tile pixel mixer.
// Pixel groups are packed with pixel 0 in the most significant DOT_W bits.
package tile_mixer_pkg;

   localparam int DOT_W  = 3;
   localparam int ATTR_W = 8;
   localparam int PRI_W  = 3;
   localparam int GD_W   = 4 * DOT_W;
   localparam int GRP_W  = 8 * DOT_W;
   localparam int PC_W   = 4;

   localparam logic [DOT_W-1:0] TRANSPARENT = 3'b111;
   localparam logic [PC_W-1:0]  PC_DONE     = 4'd8;
   localparam logic [PC_W-1:0]  PC_LAST     = 4'd7;

   typedef enum logic {
      LAYER_A = 1'b0,
      LAYER_B = 1'b1
   } layer_e;

   typedef struct packed {
      logic [DOT_W-1:0]  dot;
      logic [ATTR_W-1:0] col;
      logic              opaque;
      layer_e            layer;
   } mix_t;

   // Reverses pixel order within an 8-pixel group; bits inside each pixel keep their order.
   function automatic logic [GRP_W-1:0] reverse_pixels(input logic [GRP_W-1:0] grp);
      logic [GRP_W-1:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i*DOT_W +: DOT_W] = grp[(7-i)*DOT_W +: DOT_W];
      end
      return r;
   endfunction

endpackage

// File: rtl/tile_layer_shifter.sv
// One scroll layer: fetch buffer, active pixel shifter, active attribute,
// pixel counter and a sticky flag raised when the tile runs out before a strobe.
module tile_layer_shifter
   import tile_mixer_pkg::*;
(
   input  logic              CLK_6M,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              nib,
   input  logic [GD_W-1:0]   gd,
   input  logic [ATTR_W-1:0] attr,
   input  logic              strobe,
   input  logic              flip,
   output logic [DOT_W-1:0]  pix,
   output logic [ATTR_W-1:0] col,
   output logic              underrun
);

   logic [GRP_W-1:0]  buf_q;
   logic [ATTR_W-1:0] buf_attr;
   logic [GRP_W-1:0]  sr;
   logic [ATTR_W-1:0] col_q;
   logic [PC_W-1:0]   pc;
   logic              underrun_q;

   // NOTE: every register here uses <= so the strobe reads buf_q as it was
   // before a same-cycle LD write; a blocking write would leak the new tile in early.
   always_ff @(posedge CLK_6M) begin
      if (rst) begin
         // NOTE: the fetch buffer is only 24+8 flops, so it is cleared with the
         // rest of the state instead of being left as uninitialised storage.
         buf_q      <= '0;
         buf_attr   <= '0;
         sr         <= '1;
         col_q      <= '0;
         pc         <= PC_DONE;
         underrun_q <= 1'b0;
      end else begin
         if (wr_en) begin
            if (nib) begin
               buf_q[GD_W-1:0] <= gd;
            end else begin
               buf_q[GRP_W-1:GD_W] <= gd;
               buf_attr            <= attr;
            end
         end

         if (strobe) begin
            sr    <= flip ? reverse_pixels(buf_q) : buf_q;
            col_q <= buf_attr;
            pc    <= '0;
         end else begin
            sr <= {sr[GRP_W-DOT_W-1:0], TRANSPARENT};
            if (pc != PC_DONE) begin
               pc <= pc + 1'b1;
            end
            // Only the 7 -> 8 step flags; a counter parked at 8 since reset stays quiet.
            if (pc == PC_LAST) begin
               underrun_q <= 1'b1;
            end
         end
      end
   end

   assign pix      = sr[GRP_W-1 -: DOT_W];
   assign col      = col_q;
   assign underrun = underrun_q;

endmodule

// File: rtl/tile_pixel_mixer.sv
// Two-layer tile pixel mixer: routes graphics-ROM fetches to the layer shifters,
// resolves layer priority and registers the dot/colour pair for the palette stage.
module tile_pixel_mixer
   import tile_mixer_pkg::*;
(
   input  logic              CLK_6M,
   input  logic              rst,
   input  logic              CLK_2H,
   input  logic              LD,
   input  logic              NIB,
   input  logic [GD_W-1:0]   GD,
   input  logic [ATTR_W-1:0] ATTR,
   input  logic              HA2,
   input  logic              HB2,
   input  logic              FLIP,
   input  logic [PRI_W-1:0]  PRI_A,
   input  logic [PRI_W-1:0]  PRI_B,
   output logic [DOT_W-1:0]  DOT,
   output logic [ATTR_W-1:0] COL,
   output logic              OPAQUE,
   output logic              LAYER,
   output logic              UNDERRUN
);

   logic              wr_a, wr_b;
   logic [DOT_W-1:0]  pix_a, pix_b;
   logic [ATTR_W-1:0] col_a, col_b;
   logic              und_a, und_b;
   logic              opq_a, opq_b;
   mix_t              mix;

   assign wr_a = LD & ~CLK_2H;
   assign wr_b = LD &  CLK_2H;

   tile_layer_shifter u_layer_a (
      .CLK_6M   (CLK_6M),
      .rst      (rst),
      .wr_en    (wr_a),
      .nib      (NIB),
      .gd       (GD),
      .attr     (ATTR),
      .strobe   (HA2),
      .flip     (FLIP),
      .pix      (pix_a),
      .col      (col_a),
      .underrun (und_a)
   );

   tile_layer_shifter u_layer_b (
      .CLK_6M   (CLK_6M),
      .rst      (rst),
      .wr_en    (wr_b),
      .nib      (NIB),
      .gd       (GD),
      .attr     (ATTR),
      .strobe   (HB2),
      .flip     (FLIP),
      .pix      (pix_b),
      .col      (col_b),
      .underrun (und_b)
   );

   assign opq_a = (pix_a != TRANSPARENT);
   assign opq_b = (pix_b != TRANSPARENT);

   always_comb begin
      // NOTE: the backdrop value is assigned first so every path through the
      // if/else leaves mix driven and no latch is inferred.
      mix = '{dot: TRANSPARENT, col: '0, opaque: 1'b0, layer: LAYER_A};
      if (opq_a && (!opq_b || PRI_A >= PRI_B)) begin
         mix = '{dot: pix_a, col: col_a, opaque: 1'b1, layer: LAYER_A};
      end else if (opq_b) begin
         mix = '{dot: pix_b, col: col_b, opaque: 1'b1, layer: LAYER_B};
      end
   end

   always_ff @(posedge CLK_6M) begin
      if (rst) begin
         DOT    <= TRANSPARENT;
         COL    <= '0;
         OPAQUE <= 1'b0;
         LAYER  <= LAYER_A;
      end else begin
         DOT    <= mix.dot;
         COL    <= mix.col;
         OPAQUE <= mix.opaque;
         LAYER  <= mix.layer;
      end
   end

   assign UNDERRUN = und_a | und_b;

endmodule

// File: tb/tb_tile_pixel_mixer.sv
// Directed bench for tile_pixel_mixer: a per-cycle vector table plus hand-written
// sequences for back-to-back tiles, underrun and LD coincident with a strobe.
module tb_tile_pixel_mixer;

   logic        CLK_6M = 1'b0;
   logic        rst = 1'b1;
   logic        CLK_2H = 1'b0, LD = 1'b0, NIB = 1'b0;
   logic [11:0] GD = '0;
   logic [7:0]  ATTR = '0;
   logic        HA2 = 1'b0, HB2 = 1'b0, FLIP = 1'b0;
   logic [2:0]  PRI_A = '0, PRI_B = '0;
   logic [2:0]  DOT;
   logic [7:0]  COL;
   logic        OPAQUE, LAYER, UNDERRUN;

   int n_checks = 0;
   int n_fail   = 0;

   tile_pixel_mixer dut (
      .CLK_6M   (CLK_6M),
      .rst      (rst),
      .CLK_2H   (CLK_2H),
      .LD       (LD),
      .NIB      (NIB),
      .GD       (GD),
      .ATTR     (ATTR),
      .HA2      (HA2),
      .HB2      (HB2),
      .FLIP     (FLIP),
      .PRI_A    (PRI_A),
      .PRI_B    (PRI_B),
      .DOT      (DOT),
      .COL      (COL),
      .OPAQUE   (OPAQUE),
      .LAYER    (LAYER),
      .UNDERRUN (UNDERRUN)
   );

   always #5 CLK_6M = ~CLK_6M;

   // One record per cycle: inputs driven in that cycle, outputs expected in that same cycle.
   typedef struct {
      logic        rst, ld, h2, nib;
      logic [11:0] gd;
      logic [7:0]  attr;
      logic        ha2, hb2, flip;
      logic [2:0]  pa, pb;
      logic        chk;
      logic [2:0]  dot;
      logic        op, lay;
      logic [7:0]  col;
      logic        und;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic ld, h2, nib, input logic [11:0] gd,
                               input logic [7:0] attr, input logic ha2, hb2, flip,
                               input logic [2:0] pa, pb, dot, input logic op, lay,
                               input logic [7:0] col, input logic und);
      vec_t v;
      v = '{rst: 1'b0, ld: ld, h2: h2, nib: nib, gd: gd, attr: attr, ha2: ha2, hb2: hb2,
            flip: flip, pa: pa, pb: pb, chk: 1'b1, dot: dot, op: op, lay: lay, col: col, und: und};
      return v;
   endfunction

   function automatic vec_t rst_v();
      vec_t v;
      v = mk(0, 0, 0, 12'h0, 8'h0, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h0, 0);
      v.rst = 1'b1;
      v.chk = 1'b0;
      return v;
   endfunction

   task automatic tick();
      @(posedge CLK_6M);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; LD = 1'b0; HA2 = 1'b0; HB2 = 1'b0; FLIP = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load_a(input logic [11:0] lo, input logic [11:0] hi, input logic [7:0] attr);
      LD = 1'b1; CLK_2H = 1'b0; NIB = 1'b0; GD = lo; ATTR = attr;
      tick();
      NIB = 1'b1; GD = hi; ATTR = 8'h00;
      tick();
      LD = 1'b0;
   endtask

   initial begin
      logic [2:0] pat [8];
      logic [2:0] e_dot;
      logic [7:0] e_col;
      logic       e_op;

      pat = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4};

      // Reset followed by 20 idle cycles.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         check($sformatf("idle%0d dot", c), DOT, 3'd7);
         check($sformatf("idle%0d opaque", c), OPAQUE, 1'b0);
         check($sformatf("idle%0d underrun", c), UNDERRUN, 1'b0);
         tick();
      end

      //               ld h2 nb gd      attr   a2 b2 fl pa pb dot op ly col    und
      // Layer A, normal order; ATTR on the NIB=1 write must be ignored.
      vecs.push_back(rst_v());
      vecs.push_back(rst_v());
      vecs.push_back(mk(1, 0, 0, 12'h053, 8'h2C, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 12'h977, 8'hFF, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      for (int d = 0; d < 7; d++)
         vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'(d), 1, 0, 8'h2C, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 1));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 1));

      // Layer A flipped; FLIP drops back to 0 right after the strobe.
      vecs.push_back(rst_v());
      vecs.push_back(rst_v());
      vecs.push_back(mk(1, 0, 0, 12'h053, 8'h2C, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 12'h977, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 0, 1, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      for (int d = 6; d >= 1; d--)
         vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'(d), 1, 0, 8'h2C, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h2C, 1));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 1));

      // Priority: A all 1s, B all 2s, then B reloaded transparent.
      vecs.push_back(rst_v());
      vecs.push_back(rst_v());
      vecs.push_back(mk(1, 0, 0, 12'h249, 8'h11, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 12'h249, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 1, 0, 12'h492, 8'h22, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 1, 1, 12'h492, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 2, 5, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 1, 0, 12'hFFF, 8'h33, 0, 0, 0, 2, 5, 3'd7, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 1, 1, 12'hFFF, 8'h00, 0, 0, 0, 2, 2, 3'd2, 1, 1, 8'h22, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 2, 2, 3'd1, 1, 0, 8'h11, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 2, 5, 3'd1, 1, 0, 8'h11, 0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 2, 5, 3'd2, 1, 1, 8'h22, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 2, 5, 3'd2, 1, 1, 8'h22, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 2, 5, 3'd2, 1, 1, 8'h22, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 2, 5, 3'd1, 1, 0, 8'h11, 0));
      vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 2, 5, 3'd1, 1, 0, 8'h11, 0));

      foreach (vecs[i]) begin
         rst = vecs[i].rst; LD = vecs[i].ld; CLK_2H = vecs[i].h2; NIB = vecs[i].nib;
         GD = vecs[i].gd; ATTR = vecs[i].attr; HA2 = vecs[i].ha2; HB2 = vecs[i].hb2;
         FLIP = vecs[i].flip; PRI_A = vecs[i].pa; PRI_B = vecs[i].pb;
         if (vecs[i].chk) begin
            check($sformatf("vec%0d dot", i), DOT, vecs[i].dot);
            check($sformatf("vec%0d opaque", i), OPAQUE, vecs[i].op);
            check($sformatf("vec%0d layer", i), LAYER, vecs[i].lay);
            check($sformatf("vec%0d col", i), COL, vecs[i].col);
            check($sformatf("vec%0d underrun", i), UNDERRUN, vecs[i].und);
         end
         tick();
      end
      rst = 1'b0; LD = 1'b0; HA2 = 1'b0; HB2 = 1'b0; FLIP = 1'b0; PRI_A = '0; PRI_B = '0;

      // Four back-to-back tiles, then a missing strobe at cycle 32.
      do_reset();
      load_a(12'h053, 12'h974, 8'h5A);
      for (int c = 0; c <= 40; c++) begin
         HA2 = (c % 8 == 0) && (c < 32);
         if (c >= 2 && c <= 33) begin
            check($sformatf("seq c%0d dot", c), DOT, pat[(c-2) % 8]);
            check($sformatf("seq c%0d opaque", c), OPAQUE, 1'b1);
         end
         if (c <= 32) check($sformatf("seq c%0d underrun", c), UNDERRUN, 1'b0);
         if (c >= 34) begin
            check($sformatf("seq c%0d dot", c), DOT, 3'd7);
            check($sformatf("seq c%0d underrun", c), UNDERRUN, 1'b1);
         end
         tick();
      end
      HA2 = 1'b1;
      tick();
      HA2 = 1'b0;
      repeat (4) tick();
      check("underrun sticky after strobe", UNDERRUN, 1'b1);
      do_reset();
      repeat (3) tick();
      check("underrun cleared by rst", UNDERRUN, 1'b0);
      check("dot after rst", DOT, 3'd7);

      // LD coincident with HA2: current tile keeps the old buffer, next tile gets the new data.
      do_reset();
      load_a(12'h053, 12'h977, 8'h2C);
      HA2 = 1'b1; LD = 1'b1; CLK_2H = 1'b0; NIB = 1'b0; GD = 12'h249; ATTR = 8'h11;
      tick();
      HA2 = 1'b0; NIB = 1'b1; GD = 12'h249; ATTR = 8'h00;
      tick();
      LD = 1'b0;
      for (int c = 2; c <= 11; c++) begin
         HA2 = (c == 8);
         if (c <= 8) begin
            e_dot = 3'(c - 2); e_op = 1'b1; e_col = 8'h2C;
         end else if (c == 9) begin
            e_dot = 3'd7; e_op = 1'b0; e_col = 8'h00;
         end else begin
            e_dot = 3'd1; e_op = 1'b1; e_col = 8'h11;
         end
         check($sformatf("coinc c%0d dot", c), DOT, e_dot);
         check($sformatf("coinc c%0d opaque", c), OPAQUE, e_op);
         check($sformatf("coinc c%0d col", c), COL, e_col);
         tick();
      end
      HA2 = 1'b0;
      check("coinc underrun", UNDERRUN, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tile_pixel_mixer.md
# tile_pixel_mixer

Consumer end of the tilemap address generator's graphics-ROM fetch protocol. It captures tile graphics data and attribute bytes fetched for the two scroll layers and reloads a per-layer pixel shifter on each layer's tile-boundary strobe (HA2/HB2). It then shifts out one 3-bit dot per CLK_6M cycle and resolves priority between the two layers. The output is a registered colour/dot pair feeding the palette lookup stage.

## Interface
- DOT_W, 3, bits per pixel.
- ATTR_W, 8, tile attribute byte width (colour bank).
- PRI_W, 3, layer priority width.
- CLK_6M  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- CLK_2H  in  1  fetch layer phase: 0 = layer A, 1 = layer B.
- LD  in  1  GD/ATTR valid strobe for the layer selected by CLK_2H.
- NIB  in  1  half select for LD: 0 = left 4 pixels, 1 = right 4 pixels.
- GD  in  12  four packed pixels, pixel 0 in GD[11:9].
- ATTR  in  ATTR_W  tile attribute byte, written only when LD=1 and NIB=0.
- HA2  in  1  layer A tile-boundary strobe (one cycle).
- HB2  in  1  layer B tile-boundary strobe (one cycle).
- FLIP  in  1  horizontal flip; pixel 7 is shifted out first.
- PRI_A, PRI_B  in  PRI_W  layer priorities; higher value wins.
- DOT  out  DOT_W  winning dot; reset 3'b111.
- COL  out  ATTR_W  winning layer's attribute; reset 0.
- OPAQUE  out  1  1 when DOT comes from an opaque pixel; reset 0.
- LAYER  out  1  winning layer (0 = A, 1 = B); reset 0.
- UNDERRUN  out  1  sticky; set when either shifter exhausts before a strobe arrives; cleared only by rst; reset 0.

## Operation
- Transparent dot value is 3'b111.
- Per-layer fetch buffer: 24-bit pixel buffer plus attribute register.
  - LD with CLK_2H=L writes GD into half NIB of layer L's buffer.
  - ATTR is written alongside GD when NIB=0.
- Per-layer active state: 24-bit shift register SR, active attribute, and a 4-bit pixel counter PC (0..8, saturating).
- On strobe (HA2 for A, HB2 for B):
  - SR ← buffer (bit-reversed in pixel order if FLIP=1).
  - Active attribute ← buffered attribute.
  - PC ← 0.
- Otherwise, each cycle:
  - SR shifts by 3 toward the output end; the vacated slot fills with 3'b111.
  - PC increments, saturating at 8.
  - When PC reaches 8 and no strobe is present that cycle, UNDERRUN is set.
- Shifter output is the 3-bit output slot of SR; the pixel is opaque when it is not 3'b111.
- Mixer priority:
  - A only opaque → A.
  - B only opaque → B.
  - Both opaque → higher PRI wins; tie → A.
  - Neither opaque → DOT=3'b111, COL=0, OPAQUE=0, LAYER=0.
- FLIP is sampled only at strobe time; toggling FLIP mid-tile does not reorder pixels already loaded.

## Timing
- Strobe at cycle n: the first pixel of the new tile is at the shifter output in cycle n+1, and DOT/COL are registered at cycle n+2. Total latency from strobe to first DOT is 2 cycles.
- Eight consecutive pixels are presented per tile at one per cycle. A strobe exactly 8 cycles after the previous one gives seamless output.
- LD and strobe on the same layer in the same cycle: the strobe loads the pre-write buffer contents, and the write lands in the buffer for the next tile.
- HA2 and HB2 in the same cycle: both layers reload independently.
- Strobe earlier than 8 cycles: remaining old pixels are discarded; no error is flagged.
- rst mid-tile: next edge drives all outputs to their reset values, SR to all 1s, buffers and attributes to 0, and PC to 8. No spurious UNDERRUN is raised while PC is held at 8 from reset until the first strobe.

## Structure
- Shared package `tile_mixer_pkg` holds DOT_W, TRANSPARENT=3'b111, ATTR_W, PRI_W, and the function that reverses pixel order within a 24-bit group.
- Sub-module `tile_layer_shifter` contains buffer, SR, attribute, PC and its underrun flag, and is instantiated twice (A, B).
- The top level holds the write-enable decode from CLK_2H and LD, the priority mixer, the output register and the UNDERRUN OR.

## Test plan
- Reset, then 20 idle cycles → DOT=7, OPAQUE=0, UNDERRUN=0 throughout.
- Layer A: LD NIB0 GD=0x053 (dots 0,1,2,3), LD NIB1 GD=0x977 (dots 4,5,6,7), ATTR=0x2C, then HA2 → DOT sequence 0,1,2,3,4,5,6,7 from cycle +2. Dots 0–6 show OPAQUE=1, the final dot 7 shows OPAQUE=0, and COL=0x2C.
- Same data with FLIP=1 → DOT 7,6,5,4,3,2,1,0. The first dot (7) shows OPAQUE=0, dots 6–0 show OPAQUE=1.
- A and B both loaded opaque with PRI_A=2, PRI_B=5 → LAYER=1. With PRI_B=2 (tie) → LAYER=0. With B all 7s → LAYER=0.
- HA2 every 8 cycles for 4 tiles → continuous DOT with no transparent gaps and UNDERRUN=0. Then omit one HA2 → transparent from cycle +2 and UNDERRUN=1 latched until rst.
- LD with new data coincident with HA2 → current tile shows old buffer contents, and the next HA2 shows the new data.
